// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: synchronizes an asynchronous gray count, decodes it to binary and flags
// steps, wraps and multi-bit (illegal) changes. Optional macro GRAY_RX_ERR_CNT_EN adds err_cnt.
module gray_rx_decoder #(
    parameter int DATA_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] gray_in,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_valid,
    output logic                  step_err,
    output logic                  wrap,
    output logic                  locked
`ifdef GRAY_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        ACQ  = 1'b0,
        LOCK = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] bin_next;
    logic [CNT_W-1:0]      diff_ones;
    logic                  legal_change;
    logic                  illegal_change;
    logic                  legal_reg;
    state_t                state_reg;
    state_t                state_next;

    assign sync_q = sync_reg[SYNC_STAGES-1];
    assign diff   = sync_q ^ prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Binary bit i is the XOR of all gray bits at or above i.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_decode
            assign bin_next[gi] = ^sync_q[DATA_WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        diff_ones = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            diff_ones = diff_ones + CNT_W'(diff[i]);
        end
    end

    assign legal_change   = (diff_ones == CNT_W'(1));
    assign illegal_change = (diff_ones >= CNT_W'(2));

    // prev_q always mirrors the gray value behind bin_out, so diff != 0 exactly when bin_out changes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q    <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            legal_reg <= 1'b0;
        end else begin
            prev_q    <= sync_q;
            bin_out   <= bin_next;
            bin_valid <= (bin_next != bin_out);
            step_err  <= illegal_change;
            wrap      <= (bin_next == '0) && (&bin_out);
            legal_reg <= legal_change;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ACQ;
        end else begin
            state_reg <= state_next;
        end
    end

    // The FSM follows the registered step pulses, so locked trails the event by one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACQ:     if (legal_reg) state_next = LOCK;
            LOCK:    if (step_err)  state_next = ACQ;
            default: state_next = ACQ;
        endcase
    end

    assign locked = (state_reg == LOCK);

`ifdef GRAY_RX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt <= 8'd0;
        end else if (step_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of gray input and binary output; legal range 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count on gray_in; legal range 2..4.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port gray_in, input, DATA_WIDTH: gray count from an upstream counter, asynchronous to clk.
REQ-006 SHALL have port bin_out, output, DATA_WIDTH: registered binary decode of the synchronized gray value.
REQ-007 SHALL have port bin_valid, output, 1: one-cycle pulse, bin_out updated to a new value this cycle.
REQ-008 SHALL have port step_err, output, 1: one-cycle pulse, the accepted sample differs from the previous one in more than 1 bit.
REQ-009 SHALL have port wrap, output, 1: one-cycle pulse, bin_out moved from all-ones to zero.
REQ-010 SHALL have port locked, output, 1: high while the lock FSM is in LOCK.

Function
REQ-011 SHALL pass gray_in through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-012 SHALL hold prev_q, the last accepted gray value; prev_q loads sync_q every cycle.
REQ-013 SHALL decode sync_q to binary (bit i = XOR of gray bits DATA_WIDTH-1..i) and register it into bin_out every cycle.
REQ-014 SHALL give latency SYNC_STAGES+1 rising edges from gray_in stable to bin_out; default 3.
REQ-015 SHALL pulse bin_valid in the cycle bin_out takes a value differing from its previous value; no pulse when unchanged.
REQ-016 SHALL compute diff = sync_q XOR prev_q; step_err pulses, aligned with bin_valid, when popcount(diff) >= 2.
REQ-017 SHALL still update bin_out and pulse bin_valid on an illegal step; the error is flagged, not filtered.
REQ-018 SHALL pulse wrap, aligned with bin_valid, when the new bin_out is 0 and the previous bin_out was 2^DATA_WIDTH-1, including on an illegal step.
REQ-019 SHALL implement a 2-state FSM: ACQ (reset state) and LOCK.
REQ-020 SHALL move ACQ->LOCK on the first legal change (popcount(diff) == 1).
REQ-021 SHALL move LOCK->ACQ on any step_err.
REQ-022 SHALL hold state when no change occurs.
REQ-023 SHALL make an illegal step seen in ACQ keep the FSM in ACQ.
REQ-024 SHALL drive locked from the FSM state register (registered, no combinational path from gray_in).
REQ-025 SHALL assert the bin_valid, step_err and wrap pulses for exactly one cycle per event; back-to-back events give back-to-back pulses.

Reset
REQ-026 SHALL, while resetn is low at a clk edge, clear all sync stages, prev_q, bin_out, bin_valid, step_err, wrap and locked to 0, and set the FSM to ACQ.
REQ-027 SHALL, after resetn rises, require a full SYNC_STAGES+1 edges before any nonzero gray_in can appear on bin_out.
REQ-028 SHALL, on reset mid-operation, discard all in-flight samples; no pulse is generated by the reset itself.
REQ-029 SHALL produce no events if the first post-reset sample equals 0, which matches the upstream counter reset value.

Configuration
REQ-030 SHALL, when macro GRAY_RX_ERR_CNT_EN is defined, add output err_cnt [7:0], incremented on each step_err, saturating at 255, and cleared by reset.
REQ-031 SHALL, when GRAY_RX_ERR_CNT_EN is undefined, have no err_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover a legal count: DATA_WIDTH=4, gray_in 0->1->3->2->6, each held 4 cycles -> bin_out 1,2,3,4 with one bin_valid per step, each 3 edges after change; locked high from the first step; no step_err.
REQ-033 SHALL cover wrap: gray_in 0x8 (bin 15) then 0x0 -> bin_out 0, with bin_valid and wrap pulsing together in one cycle; step_err low.
REQ-034 SHALL cover an illegal jump: while LOCK, gray_in 0x1->0x2 -> bin_out 3, step_err and bin_valid pulse, locked drops next cycle; next legal step 0x2->0x6 -> locked rises.
REQ-035 SHALL cover reset mid-flight: gray_in changes to 0x3, resetn is pulled low 1 edge later for 1 cycle -> all outputs 0, FSM in ACQ, no bin_valid until the value re-propagates 3 edges after resetn rises.
REQ-036 SHALL cover the counter with GRAY_RX_ERR_CNT_EN defined: 300 alternating 0x0/0x3 samples -> err_cnt saturates at 255 and holds; reset -> err_cnt 0.
